mult32x32_fast_fsm: RTL

//  Control FSM for the fast 32x32 multiplier. Drives the arithmetic datapath (16-bit word

---
 rtl/mult32x32_fast_fsm.sv | 75 +++++++
 1 files changed

// File: rtl/mult32x32_fast_fsm.sv
// Control FSM for the fast 32x32 multiplier: steps the datapath through 16x16 partial
// products, skipping those whose operand MSW is known to be zero when FAST_EN is set.
module mult32x32_fast_fsm #(
  parameter int FAST_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msw_is_0,
  input  logic       b_msw_is_0,
  output logic       busy,
  output logic       done,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A0B0 = 3'd1,
    A1B0 = 3'd2,
    A0B1 = 3'd3,
    A1B1 = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   a_zero;
  logic   b_zero;

  // With FAST_EN off the flags are ignored, giving the plain four-step sequence.
  assign a_zero = (FAST_EN != 0) && a_msw_is_0;
  assign b_zero = (FAST_EN != 0) && b_msw_is_0;

  function automatic state_t step(input state_t s, input logic go,
                                  input logic az, input logic bz);
    case (s)
      IDLE:    step = go ? A0B0 : IDLE;
      A0B0:    step = !az ? A1B0 : (!bz ? A0B1 : IDLE);
      A1B0:    step = !bz ? A0B1 : IDLE;
      A0B1:    step = !az ? A1B1 : IDLE;
      default: step = IDLE;
    endcase
  endfunction

  assign next_state = step(state, start, a_zero, b_zero);

  // Outputs are registered from the upcoming state so they line up with it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      shift_sel <= 2'd0;
      upd_prod  <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= next_state != IDLE;
      upd_prod  <= next_state != IDLE;
      a_sel     <= next_state inside {A1B0, A1B1};
      b_sel     <= next_state inside {A0B1, A1B1};
      shift_sel <= (next_state == A1B1) ? 2'd2 :
                   (next_state inside {A1B0, A0B1}) ? 2'd1 : 2'd0;
      done      <= (state inside {A0B0, A1B0, A0B1, A1B1}) && (next_state == IDLE);
    end
  end

  // Product is cleared on the same edge that launches a run.
  assign clr_prod = !reset && (state == IDLE) && start;

endmodule
